// File: rtl/uart_apb_pkg.sv
// Shared definitions for the autonomous UART APB initiator: FSM states,
// UART register offsets and status register bit positions.
package uart_apb_pkg;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_CFG1_S = 4'd1,
    ST_CFG1_A = 4'd2,
    ST_GAP1   = 4'd3,
    ST_CFG2_S = 4'd4,
    ST_CFG2_A = 4'd5,
    ST_GAP    = 4'd6,
    ST_STAT_S = 4'd7,
    ST_STAT_A = 4'd8,
    ST_DECIDE = 4'd9,
    ST_TX_S   = 4'd10,
    ST_TX_A   = 4'd11,
    ST_RX_S   = 4'd12,
    ST_RX_A   = 4'd13
  } state_e;

  localparam logic [4:0] ADDR_TX   = 5'h00;
  localparam logic [4:0] ADDR_RX   = 5'h04;
  localparam logic [4:0] ADDR_CR1  = 5'h08;
  localparam logic [4:0] ADDR_CR2  = 5'h0C;
  localparam logic [4:0] ADDR_STAT = 5'h10;

  localparam int STAT_TXRDY    = 0;
  localparam int STAT_RXRDY    = 1;
  localparam int STAT_PARITY   = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_FRAMING  = 4;

  // CR2 packs the upper divisor bits above the 3-bit frame format.
  function automatic logic [7:0] cr2_value(input logic [4:0] baud_hi,
                                           input logic [2:0] frame);
    return {baud_hi, frame};
  endfunction

endpackage

// File: rtl/uart_apb_initiator.sv
// APB3 initiator that configures the UART once after reset, then polls its
// status register and moves bytes between two byte streams and the UART.
module uart_apb_initiator
  import uart_apb_pkg::*;
#(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter logic [2:0]  FRAME_CFG  = 3'b001
) (
  input  logic       PCLK,
  input  logic       PRESET,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [3:0] err_flags,
  input  logic       err_clr,
  output logic       cfg_done,
  output logic [3:0] o_dbg_state
);

  // Streams: a byte moves on an edge where valid & ready are both high.
  // valid never waits for ready; tx_ready is a single-cycle grant in DECIDE.
  state_e     r_state;
  state_e     w_next;
  logic [1:0] r_stat_q;
  logic       r_rr;
  logic [7:0] r_pwdata;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic [3:0] r_err;
  logic       r_cfg_done;

  logic       w_setup;
  logic       w_access;
  logic       w_done;
  logic       w_rx_elig;
  logic       w_tx_elig;
  logic       w_grant_rx;
  logic       w_grant_tx;
  logic [3:0] w_err_set;

  always_comb begin
    w_setup  = 1'b0;
    w_access = 1'b0;
    PWRITE   = 1'b0;
    PADDR    = ADDR_TX;
    case (r_state)
      ST_CFG1_S: begin w_setup  = 1'b1; PWRITE = 1'b1; PADDR = ADDR_CR1;  end
      ST_CFG1_A: begin w_access = 1'b1; PWRITE = 1'b1; PADDR = ADDR_CR1;  end
      ST_CFG2_S: begin w_setup  = 1'b1; PWRITE = 1'b1; PADDR = ADDR_CR2;  end
      ST_CFG2_A: begin w_access = 1'b1; PWRITE = 1'b1; PADDR = ADDR_CR2;  end
      ST_STAT_S: begin w_setup  = 1'b1; PADDR = ADDR_STAT; end
      ST_STAT_A: begin w_access = 1'b1; PADDR = ADDR_STAT; end
      ST_TX_S:   begin w_setup  = 1'b1; PWRITE = 1'b1; PADDR = ADDR_TX;   end
      ST_TX_A:   begin w_access = 1'b1; PWRITE = 1'b1; PADDR = ADDR_TX;   end
      ST_RX_S:   begin w_setup  = 1'b1; PADDR = ADDR_RX;   end
      ST_RX_A:   begin w_access = 1'b1; PADDR = ADDR_RX;   end
      default:   begin w_setup  = 1'b0; end
    endcase
  end

  always_comb begin
    case (r_state)
      ST_CFG1_S, ST_CFG1_A: PWDATA = BAUD_VALUE[7:0];
      ST_CFG2_S, ST_CFG2_A: PWDATA = cr2_value(BAUD_VALUE[12:8], FRAME_CFG);
      default:              PWDATA = r_pwdata;
    endcase
  end

  assign PSEL    = w_setup | w_access;
  assign PENABLE = w_access;
  assign w_done  = w_access & PREADY;

  // Arbitration uses only the status latched by the poll just completed.
  assign w_rx_elig  = r_stat_q[STAT_RXRDY] & ~r_rx_valid;
  assign w_tx_elig  = r_stat_q[STAT_TXRDY] & tx_valid;
  assign w_grant_rx = (r_state == ST_DECIDE) & w_rx_elig & (~w_tx_elig | ~r_rr);
  assign w_grant_tx = (r_state == ST_DECIDE) & w_tx_elig & (~w_rx_elig | r_rr);
  assign tx_ready   = w_grant_tx;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RST:    w_next = ST_CFG1_S;
      ST_CFG1_S: w_next = ST_CFG1_A;
      ST_CFG1_A: if (PREADY) w_next = ST_GAP1;
      ST_GAP1:   w_next = ST_CFG2_S;
      ST_CFG2_S: w_next = ST_CFG2_A;
      ST_CFG2_A: if (PREADY) w_next = ST_GAP;
      ST_GAP:    w_next = ST_STAT_S;
      ST_STAT_S: w_next = ST_STAT_A;
      ST_STAT_A: if (PREADY) w_next = ST_DECIDE;
      ST_DECIDE: begin
        if (w_grant_rx)      w_next = ST_RX_S;
        else if (w_grant_tx) w_next = ST_TX_S;
        else                 w_next = ST_STAT_S;
      end
      ST_TX_S:   w_next = ST_TX_A;
      ST_TX_A:   if (PREADY) w_next = ST_GAP;
      ST_RX_S:   w_next = ST_RX_A;
      ST_RX_A:   if (PREADY) w_next = ST_GAP;
      default:   w_next = ST_RST;
    endcase
  end

  always_comb begin
    w_err_set = 4'b0000;
    if ((r_state == ST_STAT_A) && w_done) begin
      w_err_set[2:0] = {PRDATA[STAT_FRAMING], PRDATA[STAT_OVERFLOW], PRDATA[STAT_PARITY]};
    end
    if (w_done && PSLVERR) begin
      w_err_set[3] = 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state    <= ST_RST;
      r_stat_q   <= 2'b00;
      r_rr       <= 1'b0;
      r_pwdata   <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_err      <= 4'b0000;
      r_cfg_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_STAT_A) && w_done) begin
        r_stat_q <= {PRDATA[STAT_RXRDY], PRDATA[STAT_TXRDY]};
      end
      if (w_grant_rx || w_grant_tx) begin
        r_rr <= ~r_rr;
      end
      if (w_grant_tx) begin
        r_pwdata <= tx_data;
      end
      if ((r_state == ST_RX_A) && w_done) begin
        r_rx_data  <= PRDATA;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      // A new error in the same cycle as err_clr must not be lost.
      r_err <= (err_clr ? 4'b0000 : r_err) | w_err_set;
      if ((r_state == ST_CFG2_A) && w_done) begin
        r_cfg_done <= 1'b1;
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign err_flags   = r_err;
  assign cfg_done    = r_cfg_done;
  assign o_dbg_state = r_state;

endmodule
